// File: rtl/mvu_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mvu_job_sequencer
// Description : Per-hart MVU job walker. It snapshots the MVU CSRs on start,
//               issues weight/input read beats over a two-level loop and one
//               output write beat per outer iteration, then pulses an irq.
// Revision    : 1.0 - initial release
// ============================================================================
module mvu_job_sequencer #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mvu_start,
    input  logic [31:0]       csr_mvu_wbaseaddr,
    input  logic [31:0]       csr_mvu_ibaseaddr,
    input  logic [31:0]       csr_mvu_obaseaddr,
    input  logic [31:0]       csr_mvu_wstride_0,
    input  logic [31:0]       csr_mvu_wstride_1,
    input  logic [31:0]       csr_mvu_istride_0,
    input  logic [31:0]       csr_mvu_istride_1,
    input  logic [31:0]       csr_mvu_ostride_0,
    input  logic [31:0]       csr_mvu_wlength_0,
    input  logic [31:0]       csr_mvu_wlength_1,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_waddr,
    output logic [ADDR_W-1:0] rd_iaddr,
    output logic              rd_last,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_oaddr,
    output logic              mvu_irq_o,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [ADDR_W-1:0] r_waddr, r_iaddr, r_oaddr, r_wrow, r_irow;
    logic [ADDR_W-1:0] r_ws0, r_ws1, r_is0, r_is1, r_os0;
    logic [CNT_W-1:0]  r_len0, r_len1, r_inner, r_outer;

    logic              w_len_zero;
    logic              w_inner_last;
    logic              w_outer_last;
    logic              w_rd_fire;
    logic              w_wr_fire;
    logic [ADDR_W-1:0] w_wrow_nxt;
    logic [ADDR_W-1:0] w_irow_nxt;

    assign w_len_zero   = (csr_mvu_wlength_0[CNT_W-1:0] == '0) ||
                          (csr_mvu_wlength_1[CNT_W-1:0] == '0);
    assign w_inner_last = (r_inner == r_len0 - c_cnt_one);
    assign w_outer_last = (r_outer == r_len1 - c_cnt_one);
    assign w_rd_fire    = (r_state == S_READ)  && rd_ready;
    assign w_wr_fire    = (r_state == S_WRITE) && wr_ready;
    assign w_wrow_nxt   = r_wrow + r_ws1;
    assign w_irow_nxt   = r_irow + r_is1;

    // Upper CSR bits beyond the address/counter width are intentionally dropped.
    logic w_unused;
    assign w_unused = &{1'b0,
                        csr_mvu_wbaseaddr[31:ADDR_W], csr_mvu_ibaseaddr[31:ADDR_W],
                        csr_mvu_obaseaddr[31:ADDR_W], csr_mvu_wstride_0[31:ADDR_W],
                        csr_mvu_wstride_1[31:ADDR_W], csr_mvu_istride_0[31:ADDR_W],
                        csr_mvu_istride_1[31:ADDR_W], csr_mvu_ostride_0[31:ADDR_W],
                        csr_mvu_wlength_0[31:CNT_W],  csr_mvu_wlength_1[31:CNT_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (mvu_start) begin
                    w_state_nxt = w_len_zero ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (w_rd_fire && w_inner_last) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_wr_fire) begin
                    w_state_nxt = w_outer_last ? S_DONE : S_READ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waddr <= '0;
            r_iaddr <= '0;
            r_oaddr <= '0;
            r_wrow  <= '0;
            r_irow  <= '0;
            r_ws0   <= '0;
            r_ws1   <= '0;
            r_is0   <= '0;
            r_is1   <= '0;
            r_os0   <= '0;
            r_len0  <= '0;
            r_len1  <= '0;
            r_inner <= '0;
            r_outer <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mvu_start) begin
                        r_waddr <= csr_mvu_wbaseaddr[ADDR_W-1:0];
                        r_wrow  <= csr_mvu_wbaseaddr[ADDR_W-1:0];
                        r_iaddr <= csr_mvu_ibaseaddr[ADDR_W-1:0];
                        r_irow  <= csr_mvu_ibaseaddr[ADDR_W-1:0];
                        r_oaddr <= csr_mvu_obaseaddr[ADDR_W-1:0];
                        r_ws0   <= csr_mvu_wstride_0[ADDR_W-1:0];
                        r_ws1   <= csr_mvu_wstride_1[ADDR_W-1:0];
                        r_is0   <= csr_mvu_istride_0[ADDR_W-1:0];
                        r_is1   <= csr_mvu_istride_1[ADDR_W-1:0];
                        r_os0   <= csr_mvu_ostride_0[ADDR_W-1:0];
                        r_len0  <= csr_mvu_wlength_0[CNT_W-1:0];
                        r_len1  <= csr_mvu_wlength_1[CNT_W-1:0];
                        r_inner <= '0;
                        r_outer <= '0;
                    end
                end
                S_READ: begin
                    if (w_rd_fire && !w_inner_last) begin
                        r_inner <= r_inner + c_cnt_one;
                        r_waddr <= r_waddr + r_ws0;
                        r_iaddr <= r_iaddr + r_is0;
                    end
                end
                S_WRITE: begin
                    // Next outer row restarts the inner walk from the advanced row bases.
                    if (w_wr_fire && !w_outer_last) begin
                        r_outer <= r_outer + c_cnt_one;
                        r_inner <= '0;
                        r_oaddr <= r_oaddr + r_os0;
                        r_wrow  <= w_wrow_nxt;
                        r_irow  <= w_irow_nxt;
                        r_waddr <= w_wrow_nxt;
                        r_iaddr <= w_irow_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_valid  = (r_state == S_READ);
    assign rd_waddr  = r_waddr;
    assign rd_iaddr  = r_iaddr;
    assign rd_last   = (r_state == S_READ) && w_inner_last;
    assign wr_valid  = (r_state == S_WRITE);
    assign wr_oaddr  = r_oaddr;
    assign mvu_irq_o = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
